// File: rtl/cfg_bus_pkg.sv
// Shared types and default sizing for the config-register bus initiator.
package cfg_bus_pkg;

  localparam int DEF_DATA_W  = 3;
  localparam int DEF_NUM_TGT = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Clear/enable up-counter; done flags the cycle whose increment reaches TIMEOUT.
module cfg_timeout_ctr #(
  parameter  int TIMEOUT = 15,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cfg_reg_initiator.sv
// Host-side initiator driving per-register wen/ren strobes with one command in flight.
// Optional CFG_INIT_READBACK_EN: every write is verified by reading the target back.
//
// state   | meaning
// IDLE    | waiting for a command (cmd_ready high)
// WRITE   | one-cycle write strobe to the addressed target
// READ    | read strobe held until target ready or timeout
// RESP    | response held on rsp_* until host accepts
module cfg_reg_initiator
  import cfg_bus_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NUM_TGT = DEF_NUM_TGT,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int ADDR_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_TGT-1:0]        tgt_wen,
  output logic [NUM_TGT-1:0]        tgt_ren,
  output logic [DATA_W-1:0]         tgt_wdata,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [NUM_TGT-1:0]        tgt_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef CFG_INIT_READBACK_EN
  localparam state_t WRITE_NEXT = S_READ;
`else
  localparam state_t WRITE_NEXT = S_RESP;
`endif

  state_t             state_q, state_d;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               cmd_ready_q;
  logic [CNT_W-1:0]   cnt;
  logic               done;
  logic               accept;
  logic               bad_addr;
  logic [DATA_W-1:0]  sel_rdata;
  logic               sel_ready;

  cfg_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != S_READ),
    .en   (state_q == S_READ),
    .cnt  (cnt),
    .done (done)
  );

  assign accept    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign bad_addr  = {1'b0, cmd_addr} >= (ADDR_W + 1)'(NUM_TGT);
  assign sel_rdata = tgt_rdata[int'(addr_q) * DATA_W +: DATA_W];
  assign sel_ready = tgt_ready[addr_q];

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_addr) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (cmd_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        state_d = WRITE_NEXT;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      S_READ: begin
        // target ready lags ren by a register, so the first READ cycle never completes
        if ((cnt != '0) && sel_ready) begin
          state_d = S_RESP;
          if (write_q && (sel_rdata != wdata_q)) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d   = 1'b0;
            rdata_d = sel_rdata;
          end
        end else if (done) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == S_IDLE);
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  end

  always_comb begin
    tgt_wen = '0;
    tgt_ren = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      tgt_wen[i] = (state_q == S_WRITE) && (addr_q == ADDR_W'(i));
      tgt_ren[i] = (state_q == S_READ) && (addr_q == ADDR_W'(i));
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tgt_wdata = wdata_q;

endmodule

// File: tb/tb_cfg_reg_initiator.sv
// Directed bench for cfg_reg_initiator with three modelled targets (registered ready).
module tb_cfg_reg_initiator;

  localparam int DW = 3;
  localparam int NT = 3;
  localparam int TO = 15;
  localparam int AW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [DW-1:0]    cmd_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [NT-1:0]    tgt_wen;
  logic [NT-1:0]    tgt_ren;
  logic [DW-1:0]    tgt_wdata;
  logic [NT*DW-1:0] tgt_rdata;
  logic [NT-1:0]    tgt_ready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cfg_reg_initiator #(.DATA_W(DW), .NUM_TGT(NT), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .tgt_wen   (tgt_wen),
    .tgt_ren   (tgt_ren),
    .tgt_wdata (tgt_wdata),
    .tgt_rdata (tgt_rdata),
    .tgt_ready (tgt_ready)
  );

  // Target bank: target 1 never raises ready; corrupt makes writes store zero.
  logic [DW-1:0] mem [NT];
  logic [NT-1:0] rdy_q;
  logic [NT-1:0] rdy_en = 3'b101;
  logic          corrupt = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 3'b000;
      mem[1] <= 3'b011;
      mem[2] <= 3'b110;
      rdy_q  <= '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (tgt_wen[i]) mem[i] <= corrupt ? '0 : tgt_wdata;
        rdy_q[i] <= tgt_ren[i] & rdy_en[i];
      end
    end
  end

  assign tgt_rdata = {mem[2], mem[1], mem[0]};
  assign tgt_ready = rdy_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the handshake edge (cycle 1).
  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    compared++;
    if (cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_rsp: got %b required 00000", {rsp_valid, rsp_err, rsp_rdata});
    end
    compared++;
    if ({tgt_wen, tgt_ren, tgt_wdata} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b required 0", {tgt_wen, tgt_ren, tgt_wdata});
    end
    rst = 1'b0;
    tick();
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 2'd0, 3'b101);
    compared++;
    if ({tgt_wen, tgt_ren, tgt_wdata, rsp_valid} !== {3'b001, 3'b000, 3'b101, 1'b0}) begin
      mismatched++;
      $display("FAIL write_c1: wen/ren/wdata/valid got %b required %b",
               {tgt_wen, tgt_ren, tgt_wdata, rsp_valid}, {3'b001, 3'b000, 3'b101, 1'b0});
    end
    tick();
`ifdef CFG_INIT_READBACK_EN
    compared++;
    if ({tgt_wen, tgt_ren, rsp_valid} !== {3'b000, 3'b001, 1'b0}) begin
      mismatched++;
      $display("FAIL write_rb_c2: wen/ren/valid got %b required 0000010", {tgt_wen, tgt_ren, rsp_valid});
    end
    tick();
    tick();
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren} !== {1'b1, 1'b0, 3'b101, 6'b0}) begin
      mismatched++;
      $display("FAIL write_rb_rsp: valid/err/rdata/strobes got %b required 1010 1000000",
               {rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren});
    end
`else
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren} !== {1'b1, 1'b0, 3'b000, 6'b0}) begin
      mismatched++;
      $display("FAIL write_rsp_c2: valid/err/rdata/strobes got %b required 10000000000",
               {rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren});
    end
`endif
    tick();
    compared++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL write_done: valid/cmd_ready got %b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 2'd2, 3'b000);
    compared++;
    if ({tgt_ren, tgt_wen, rsp_valid} !== {3'b100, 3'b000, 1'b0}) begin
      mismatched++;
      $display("FAIL read_c1: ren/wen/valid got %b required 1000000", {tgt_ren, tgt_wen, rsp_valid});
    end
    tick();
    compared++;
    if ({tgt_ren, rsp_valid} !== {3'b100, 1'b0}) begin
      mismatched++;
      $display("FAIL read_c2: ren/valid got %b required 1000", {tgt_ren, rsp_valid});
    end
    tick();
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata, tgt_ren} !== {1'b1, 1'b0, 3'b110, 3'b000}) begin
      mismatched++;
      $display("FAIL read_rsp_c3: valid/err/rdata/ren got %b required 10110000",
               {rsp_valid, rsp_err, rsp_rdata, tgt_ren});
    end
    tick();
  endtask

  task automatic test_timeout();
    int ren_cnt, stray, rsp_cyc;
    logic [DW-1:0] r_data;
    logic r_err;
    logic [NT-1:0] r_ren;
    ren_cnt = 0;
    stray   = 0;
    rsp_cyc = 0;
    r_data  = '1;
    r_err   = 1'b0;
    r_ren   = '1;
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 2'd1, 3'b000);
    for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
      if (tgt_ren == 3'b010) ren_cnt++;
      else if (tgt_ren != 3'b000 || tgt_wen != 3'b000) stray++;
      if (rsp_valid === 1'b1) begin
        rsp_cyc = c;
        r_data  = rsp_rdata;
        r_err   = rsp_err;
        r_ren   = tgt_ren;
      end
      if (rsp_cyc == 0) tick();
    end
    compared++;
    if (ren_cnt != TO || stray != 0) begin
      mismatched++;
      $display("FAIL timeout_ren_cycles: got %0d (stray %0d) required %0d (stray 0)", ren_cnt, stray, TO);
    end
    compared++;
    if (rsp_cyc != TO + 1) begin
      mismatched++;
      $display("FAIL timeout_rsp_cycle: got %0d required %0d", rsp_cyc, TO + 1);
    end
    compared++;
    if ({r_err, r_data, r_ren} !== {1'b1, 3'b000, 3'b000}) begin
      mismatched++;
      $display("FAIL timeout_rsp: err/rdata/ren got %b required 1000000", {r_err, r_data, r_ren});
    end
    tick();
  endtask

  task automatic test_bad_addr();
    rsp_ready = 1'b1;
    issue_cmd(1'b1, 2'd3, 3'b111);
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren} !== {1'b1, 1'b1, 3'b000, 6'b0}) begin
      mismatched++;
      $display("FAIL bad_addr_rsp: valid/err/rdata/strobes got %b required 11000000000",
               {rsp_valid, rsp_err, rsp_rdata, tgt_wen, tgt_ren});
    end
    tick();
    compared++;
    if ({rsp_valid, tgt_wen, tgt_ren, cmd_ready} !== {1'b0, 6'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL bad_addr_after: valid/strobes/cmd_ready got %b required 00000001",
               {rsp_valid, tgt_wen, tgt_ren, cmd_ready});
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 2'd2, 3'b000);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 2'd0;
    cmd_wdata = 3'b010;
    for (int k = 0; k < 5; k++) begin
      compared++;
      if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, tgt_wen, tgt_ren} !==
          {1'b1, 3'b110, 1'b0, 1'b0, 3'b000, 3'b000}) begin
        mismatched++;
        $display("FAIL backpressure_hold%0d: valid/rdata/err/ready/wen/ren got %b required 111000000000",
                 k, {rsp_valid, rsp_rdata, rsp_err, cmd_ready, tgt_wen, tgt_ren});
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    compared++;
    if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {1'b0, 3'b000, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL backpressure_release: valid/rdata/err/ready got %b required 000001",
               {rsp_valid, rsp_rdata, rsp_err, cmd_ready});
    end
    tick();
    compared++;
    if ({tgt_wen, tgt_ren, rsp_valid, cmd_ready} !== {6'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL dropped_valid: wen/ren/valid/ready got %b required 00000001",
               {tgt_wen, tgt_ren, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset_mid_read();
    int saw_rsp;
    saw_rsp = 0;
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 2'd2, 3'b000);
    compared++;
    if (tgt_ren !== 3'b100) begin
      mismatched++;
      $display("FAIL midrst_ren_before: got %b required 100", tgt_ren);
    end
    rst = 1'b1;
    tick();
    compared++;
    if ({tgt_wen, tgt_ren, rsp_valid, cmd_ready} !== 8'b0) begin
      mismatched++;
      $display("FAIL midrst_outputs: wen/ren/valid/ready got %b required 00000000",
               {tgt_wen, tgt_ren, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid !== 1'b0) saw_rsp++;
    end
    compared++;
    if (saw_rsp != 0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_no_rsp: rsp cycles %0d ready %b required 0 and 1", saw_rsp, cmd_ready);
    end
    issue_cmd(1'b0, 2'd2, 3'b000);
    tick();
    tick();
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 3'b110}) begin
      mismatched++;
      $display("FAIL midrst_next_read: valid/err/rdata got %b required 10110",
               {rsp_valid, rsp_err, rsp_rdata});
    end
    tick();
  endtask

`ifdef CFG_INIT_READBACK_EN
  task automatic test_readback_corrupt();
    rsp_ready = 1'b1;
    corrupt   = 1'b1;
    issue_cmd(1'b1, 2'd0, 3'b011);
    tick();
    tick();
    tick();
    compared++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 3'b000}) begin
      mismatched++;
      $display("FAIL readback_corrupt: valid/err/rdata got %b required 11000",
               {rsp_valid, rsp_err, rsp_rdata});
    end
    corrupt = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_bad_addr();
    test_backpressure();
    test_reset_mid_read();
`ifdef CFG_INIT_READBACK_EN
    test_readback_corrupt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
